cosine_similarity_kernel: RTL and testbench
===========================================

# cosine_similarity_kernel

Streaming accumulator that produces the three dot products needed for cosine similarity between hypervectors A and B: AA = Σa·a, BB = Σb·b and AB = Σa·b. Element words of A and B arrive interleaved on one data port under a valid/first/last handshake. The block sits after the hypervector memory read path and feeds the similarity divider/comparator stage. Final sums are registered and flagged with `done`.

## Interface
- `HV_DATA_WIDTH`, default 32: width of one element word, of the accumulators' output view and of every data port.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  reset: asynchronous, active-low; one clock domain.
- `valid`  in  1  `data_in` holds a beat; accepted on a rising edge where `valid && ready`.
- `first`  in  1  qualifies the first beat of a vector pair; clears the accumulators.
- `last`  in  1  qualifies the final beat of the stream.
- `data_in`  in  W  element word, signed two's complement.
- `AA_out`, `BB_out`, `AB_out`  out  W each  final sums, signed, held until the next result.
- `ready`  out  1  block can accept a beat this cycle.
- `done`  out  1  final sums valid; level signal.

## Operation
- Beat order within a stream: even beats (0, 2, …) are a_i; odd beats (1, 3, …) are b_i. Pair i is (beat 2i, beat 2i+1).
- States:
  - IDLE: `ready`=1; beats without `first` are ignored.
  - ACCUM: `ready`=1.
  - FLUSH: `ready`=0.
  - DONE: `ready`=1, `done`=1.
- Transitions:
  - An accepted `first` beat in any ready state clears the accumulators and the parity bit, moves to ACCUM and is taken as a_0. This also applies mid-stream (restart).
  - An accepted `last` beat moves to FLUSH.
  - Pipeline drained moves to DONE.
  - `done` clears on the next accepted `first`.
- If `last` falls on an A beat (odd beat count, including `first`&&`last` on the same beat), the missing b is 0.
- Arithmetic:
  - Products are full 2W-bit signed.
  - Accumulators are ACC_W = 2W+16 bits signed.
  - Output is the low W bits of each accumulator (modulo-2^W wrap) unless saturation is compiled in.
- On reset: all outputs 0, `ready`=1, `done`=0, state IDLE, accumulators 0.
- Reset mid-stream aborts the stream with no partial result; sums restart from 0 on the next `first`.

## Timing
- Edge E accepts a B beat: pair latched at E, products registered at E+1, accumulated at E+2.
- `last` accepted at edge L: FLUSH begins (`ready`=0 from L).
- At L+3 the outputs load and `done` rises; `ready` returns to 1.
- Max throughput: one beat per clock.
- Outputs change only on the edge that raises `done`; they are stable while `done`=1 and afterwards until the next result.
- `valid` while `ready`=0 is ignored (not queued).

## Configuration
- `COSSIM_SATURATE_EN` defined: each output clamps its ACC_W accumulator to [−2^(W−1), 2^(W−1)−1].
- Not defined: each output wraps modulo 2^W (low W bits).

## Structure
- Package `cossim_pkg`:
  - state enum (IDLE, ACCUM, FLUSH, DONE).
  - `ACC_W` as a function of W.
  - `cossim_sat` function (clamp wide to W).
- One sub-module `cossim_mac`: registered signed multiply + ACC_W accumulate with synchronous clear. Instantiated three times (aa, bb, ab).
- The top level holds the FSM, the A-word holding register, the parity bit and the output registers.

## Test plan
- Single pair a=3, b=4 (`first` on beat 0, `last` on beat 1) -> AA=9, BB=16, AB=12; `done` rises exactly 3 edges after the `last` acceptance edge.
- Pairs (1,2),(3,−1) -> AA=10, BB=5, AB=0xFFFFFFFF (−1); `ready` low only during the 3 FLUSH cycles.
- Single beat 5 with `first`&&`last` -> AA=25, BB=0, AB=0.
- Pair (0x10000, 0x10000):
  - without macro -> AA=BB=AB=0 (wrap);
  - with `COSSIM_SATURATE_EN` -> all three = 0x7FFFFFFF.
- Restart and stray beats:
  - stream (7,7), then a new `first` with (2,3),last -> AA=4, BB=9, AB=6;
  - beats with `valid` but no `first` in IDLE -> no state change.
- Assert `reset_n` low mid-stream -> all outputs 0, `ready`=1, `done`=0 asynchronously; a following stream (1,1),last -> AA=BB=AB=1.

Source files
------------

// File: rtl/cossim_pkg.sv
// Shared types and helpers for the cosine-similarity dot-product kernel.
package cossim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StDone
  } cossim_state_e;

  // Widest element word the saturation helper supports.
  localparam int unsigned MaxW    = 64;
  localparam int unsigned MaxAccW = 2 * MaxW + 16;

  function automatic int unsigned cossim_acc_w(input int unsigned w);
    return 2 * w + 16;
  endfunction

  // Clamp a sign-extended accumulator to the signed range of a w-bit word.
  function automatic logic [MaxW-1:0] cossim_sat(input logic signed [MaxAccW-1:0] value,
                                                 input int unsigned w);
    logic signed [MaxAccW-1:0] one;
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (w - 1)) - one;
    lo     = -hi - one;
    if (value > hi) begin
      return hi[MaxW-1:0];
    end else if (value < lo) begin
      return lo[MaxW-1:0];
    end
    return value[MaxW-1:0];
  endfunction

endpackage

// File: rtl/cossim_if.sv
// Beat stream in, three registered dot products plus handshake out.
interface cossim_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         first;
  logic         last;
  logic [W-1:0] data_in;
  logic         ready;
  logic         done;
  logic [W-1:0] AA_out;
  logic [W-1:0] BB_out;
  logic [W-1:0] AB_out;

  modport master (
    output valid, first, last, data_in,
    input  ready, done, AA_out, BB_out, AB_out
  );

  modport slave (
    input  valid, first, last, data_in,
    output ready, done, AA_out, BB_out, AB_out
  );
endinterface

// File: rtl/cossim_mac.sv
// Registered signed multiply followed by a wide accumulator with synchronous clear.
module cossim_mac
  import cossim_pkg::*;
#(
  parameter int unsigned W    = 32,
  localparam int unsigned AccW = cossim_acc_w(W)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   accumulate,
  input  logic signed [W-1:0]    a,
  input  logic signed [W-1:0]    b,
  output logic signed [AccW-1:0] acc
);

  logic signed [2*W-1:0]  prod_q;
  logic signed [AccW-1:0] acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (load) begin
        prod_q <= (2 * W)'(a) * (2 * W)'(b);
      end
      if (clear) begin
        acc_q <= '0;
      end else if (accumulate) begin
        acc_q <= acc_q + AccW'(prod_q);
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cosine_similarity_kernel.sv
// Streams interleaved A/B words into AA, BB and AB dot products.
// Define COSSIM_SATURATE_EN to clamp outputs instead of wrapping them.
module cosine_similarity_kernel
  import cossim_pkg::*;
#(
  parameter int unsigned HV_DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     reset_n,
  cossim_if.slave bus
);

  localparam int unsigned W    = HV_DATA_WIDTH;
  localparam int unsigned AccW = cossim_acc_w(W);

  cossim_state_e          state_q, state_d;
  logic                   parity_q, parity_d;
  logic signed [W-1:0]    a_hold_q, a_hold_d;
  logic signed [W-1:0]    pair_a_q, pair_a_d;
  logic signed [W-1:0]    pair_b_q, pair_b_d;
  logic                   pair_valid_q, pair_valid_d;
  logic                   prod_valid_q, prod_valid_d;
  logic [W-1:0]           aa_q, bb_q, ab_q;
  logic [W-1:0]           aa_d, bb_d, ab_d;
  logic signed [AccW-1:0] acc_aa, acc_bb, acc_ab;
  logic signed [W-1:0]    data_s;
  logic                   accept, clear, take_beat, drained, load_out;

  assign data_s    = bus.data_in;
  assign accept    = bus.valid && bus.ready;
  assign clear     = accept && bus.first;
  assign take_beat = accept && (bus.first || state_q == StAccum);
  assign drained   = !pair_valid_q && !prod_valid_q;
  // A restart drops any pair of the old stream still in flight.
  assign prod_valid_d = pair_valid_q && !clear;

  always_comb begin
    state_d      = state_q;
    parity_d     = parity_q;
    a_hold_d     = a_hold_q;
    pair_a_d     = pair_a_q;
    pair_b_d     = pair_b_q;
    pair_valid_d = 1'b0;
    load_out     = 1'b0;
    unique case (state_q)
      StIdle, StAccum, StDone: begin
        if (take_beat) begin
          state_d = bus.last ? StFlush : StAccum;
          if (parity_q && !bus.first) begin
            pair_a_d     = a_hold_q;
            pair_b_d     = data_s;
            pair_valid_d = 1'b1;
            parity_d     = 1'b0;
          end else begin
            // A word; a trailing one pairs with an implicit zero B.
            a_hold_d     = data_s;
            pair_a_d     = data_s;
            pair_b_d     = '0;
            pair_valid_d = bus.last;
            parity_d     = !bus.last;
          end
        end
      end
      StFlush: begin
        if (drained) begin
          state_d  = StDone;
          load_out = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      parity_q     <= 1'b0;
      a_hold_q     <= '0;
      pair_a_q     <= '0;
      pair_b_q     <= '0;
      pair_valid_q <= 1'b0;
      prod_valid_q <= 1'b0;
      aa_q         <= '0;
      bb_q         <= '0;
      ab_q         <= '0;
    end else begin
      state_q      <= state_d;
      parity_q     <= parity_d;
      a_hold_q     <= a_hold_d;
      pair_a_q     <= pair_a_d;
      pair_b_q     <= pair_b_d;
      pair_valid_q <= pair_valid_d;
      prod_valid_q <= prod_valid_d;
      if (load_out) begin
        aa_q <= aa_d;
        bb_q <= bb_d;
        ab_q <= ab_d;
      end
    end
  end

  cossim_mac #(.W(W)) u_mac_aa (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (pair_valid_q),
    .accumulate(prod_valid_q),
    .a         (pair_a_q),
    .b         (pair_a_q),
    .acc       (acc_aa)
  );

  cossim_mac #(.W(W)) u_mac_bb (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (pair_valid_q),
    .accumulate(prod_valid_q),
    .a         (pair_b_q),
    .b         (pair_b_q),
    .acc       (acc_bb)
  );

  cossim_mac #(.W(W)) u_mac_ab (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (pair_valid_q),
    .accumulate(prod_valid_q),
    .a         (pair_a_q),
    .b         (pair_b_q),
    .acc       (acc_ab)
  );

`ifdef COSSIM_SATURATE_EN
  logic [MaxW-1:0] aa_sat, bb_sat, ab_sat;
  always_comb begin
    aa_sat = cossim_sat(MaxAccW'(acc_aa), W);
    bb_sat = cossim_sat(MaxAccW'(acc_bb), W);
    ab_sat = cossim_sat(MaxAccW'(acc_ab), W);
  end
  assign aa_d = aa_sat[W-1:0];
  assign bb_d = bb_sat[W-1:0];
  assign ab_d = ab_sat[W-1:0];
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^{acc_aa[AccW-1:W], acc_bb[AccW-1:W], acc_ab[AccW-1:W]};
  assign aa_d = acc_aa[W-1:0];
  assign bb_d = acc_bb[W-1:0];
  assign ab_d = acc_ab[W-1:0];
`endif

  assign bus.ready  = (state_q != StFlush);
  assign bus.done   = (state_q == StDone);
  assign bus.AA_out = aa_q;
  assign bus.BB_out = bb_q;
  assign bus.AB_out = ab_q;

endmodule

// File: tb/tb_cosine_similarity_kernel.sv
// Self-checking bench: directed scenarios plus random streams against a pairwise-sum model.
module tb_cosine_similarity_kernel;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cossim_if #(.W(W)) bus ();

  cosine_similarity_kernel #(.HV_DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int           checks = 0;
  int           errors = 0;
  int           beats[$];
  logic [W-1:0] exp_aa, exp_bb, exp_ab;
  int           lat, ready_low;
  bit           timed_out;

  function automatic logic [W-1:0] fold(input longint s);
`ifdef COSSIM_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[W-1:0];
  endfunction

  // Sum over pairs (beat 2i, beat 2i+1); a lone trailing A pairs with 0.
  task automatic compute_expected();
    longint saa = 0, sbb = 0, sab = 0, a, b;
    for (int i = 0; i < beats.size(); i += 2) begin
      a = longint'(beats[i]);
      b = (i + 1 < beats.size()) ? longint'(beats[i+1]) : 64'sd0;
      saa += a * a;
      sbb += b * b;
      sab += a * b;
    end
    exp_aa = fold(saa);
    exp_bb = fold(sbb);
    exp_ab = fold(sab);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_beat(input int data, input bit f, input bit l);
    int guard = 0;
    while (bus.ready !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait ready=%b want 1", bus.ready);
    end
    bus.valid   = 1'b1;
    bus.first   = f;
    bus.last    = l;
    bus.data_in = data;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.first = 1'b0;
    bus.last  = 1'b0;
  endtask

  task automatic wait_done();
    lat       = 0;
    ready_low = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.ready === 1'b0) ready_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = (bus.done !== 1'b1);
  endtask

  task automatic drive_stream();
    for (int i = 0; i < beats.size(); i++) begin
      send_beat(beats[i], i == 0, i == beats.size() - 1);
    end
    wait_done();
  endtask

  task automatic test_reset();
    bus.valid   = 1'b0;
    bus.first   = 1'b0;
    bus.last    = 1'b0;
    bus.data_in = '0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ready=%b done=%b want 1/0", bus.ready, bus.done);
    end
    checks++;
    if ({bus.AA_out, bus.BB_out, bus.AB_out} !== 96'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h want 0", bus.AA_out, bus.BB_out, bus.AB_out);
    end
  endtask

  task automatic test_stray_idle();
    send_beat(9, 1'b0, 1'b0);
    send_beat(9, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.AA_out !== 32'd0) begin
      errors++;
      $display("FAIL stray_idle done=%b ready=%b aa=%h want 0/1/0", bus.done, bus.ready,
               bus.AA_out);
    end
  endtask

  task automatic test_stream(input string name, input int b0, input int b1, input int b2,
                             input int b3, input int n);
    int src[4];
    src   = '{b0, b1, b2, b3};
    beats = {};
    for (int i = 0; i < n; i++) beats.push_back(src[i]);
    compute_expected();
    drive_stream();
    checks++;
    if (timed_out || lat != 3) begin
      errors++;
      $display("FAIL %s_latency got %0d edges want 3", name, lat);
    end
    checks++;
    if (ready_low != 3) begin
      errors++;
      $display("FAIL %s_ready_low got %0d cycles want 3", name, ready_low);
    end
    checks++;
    if (bus.AA_out !== exp_aa || bus.BB_out !== exp_bb || bus.AB_out !== exp_ab) begin
      errors++;
      $display("FAIL %s_sums got %h %h %h want %h %h %h", name, bus.AA_out, bus.BB_out,
               bus.AB_out, exp_aa, exp_bb, exp_ab);
    end
  endtask

  task automatic test_stray_done();
    send_beat(11, 1'b0, 1'b1);
    send_beat(13, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.AA_out !== exp_aa || bus.AB_out !== exp_ab) begin
      errors++;
      $display("FAIL stray_done done=%b aa=%h ab=%h want 1 %h %h", bus.done, bus.AA_out,
               bus.AB_out, exp_aa, exp_ab);
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] prev_aa;
    prev_aa = exp_aa;
    send_beat(7, 1'b1, 1'b0);
    checks++;
    if (bus.done !== 1'b0 || bus.AA_out !== prev_aa) begin
      errors++;
      $display("FAIL restart_done_clear done=%b aa=%h want 0 %h", bus.done, bus.AA_out, prev_aa);
    end
    send_beat(7, 1'b0, 1'b0);
    send_beat(2, 1'b1, 1'b0);
    send_beat(3, 1'b0, 1'b1);
    wait_done();
    beats = '{2, 3};
    compute_expected();
    checks++;
    if (timed_out || bus.AA_out !== 32'd4 || bus.BB_out !== 32'd9 || bus.AB_out !== 32'd6) begin
      errors++;
      $display("FAIL restart_sums got %h %h %h want 4 9 6", bus.AA_out, bus.BB_out, bus.AB_out);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(5, 1'b1, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 ||
        {bus.AA_out, bus.BB_out, bus.AB_out} !== 96'd0) begin
      errors++;
      $display("FAIL reset_mid ready=%b done=%b out=%h %h %h want 1/0/0", bus.ready, bus.done,
               bus.AA_out, bus.BB_out, bus.AB_out);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_stream("after_reset", 1, 1, 0, 0, 2);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 10; s++) begin
      int n;
      n     = int'($urandom_range(1, 12));
      beats = {};
      for (int i = 0; i < n; i++) begin
        beats.push_back(int'($urandom_range(0, 2097151)) - 1048576);
      end
      compute_expected();
      drive_stream();
      checks++;
      if (timed_out || lat != 3) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d want 3", s, lat);
      end
      checks++;
      if (bus.AA_out !== exp_aa || bus.BB_out !== exp_bb || bus.AB_out !== exp_ab) begin
        errors++;
        $display("FAIL rand%0d_sums len %0d got %h %h %h want %h %h %h", s, n, bus.AA_out,
                 bus.BB_out, bus.AB_out, exp_aa, exp_bb, exp_ab);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stray_idle();
    test_stream("single_pair", 3, 4, 0, 0, 2);
    test_stray_done();
    test_stream("two_pairs", 1, 2, 3, -1, 4);
    test_stream("single_beat", 5, 0, 0, 0, 1);
    test_stream("big_pair", 32'h10000, 32'h10000, 0, 0, 2);
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
